// File: rtl/mac_dot4_seq.sv
// ---------------------------------------------------------------------------
// mac_dot4_seq : sequential dot-product / multiply-accumulate stage.
//
// Wraps the 4x4 combinational multiplier `main` with input registering,
// accumulation and valid/ready flow control. A burst of `len` unsigned 4-bit
// operand pairs is accepted, each product is added into an ACC_W-bit
// accumulator (wrapping), and the sum is offered on a result handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a burst (sampled only while idle)
//   len        number of operand pairs, captured with start
//   in_valid   operand pair valid
//   in_ready   block accepts an operand pair this cycle
//   x, y       unsigned 4-bit operands
//   busy       burst in progress or result pending
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     accumulated sum modulo 2^ACC_W
//   ovf        sticky carry-out of the accumulator within the burst
//
// Also contains `main`, the 4x4 unsigned combinational multiplier core
// (a_i, b_i -> 8-bit product p_o).
// ---------------------------------------------------------------------------

module main (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  // Shift-and-add array: one partial product per multiplier bit.
  always_comb begin
    p_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (b_i[i]) p_o = p_o + ({4'b0000, a_i} << i);
    end
  end

endmodule

module mac_dot4_seq #(
  parameter int ACC_W = 12,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       x,
  input  logic [3:0]       y,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Zero-extend the product and add with one extra bit to expose the carry.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [7:0]       p);
    return {1'b0, a} + {{(ACC_W-7){1'b0}}, p};
  endfunction

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] in_cnt_q;
  logic [LEN_W-1:0] acc_cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;

  logic             vld_p1_q;
  logic [3:0]       x_p1_q;
  logic [3:0]       y_p1_q;
  logic [7:0]       prod_p1;
  logic [ACC_W:0]   acc_sum_d;
  logic             accept;
  logic             last_acc;

  assign in_ready  = (state_q == S_RUN) && (in_cnt_q < len_q);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = acc_q;
  assign ovf       = ovf_q;

  // ---- stage p1: registered operand pair (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      x_p1_q <= x;
      y_p1_q <= y;
    end
  end

  main u_mul (
    .a_i (x_p1_q),
    .b_i (y_p1_q),
    .p_o (prod_p1)
  );

  assign acc_sum_d = acc_add(acc_q, prod_p1);
  assign last_acc  = (acc_cnt_q == len_q - 1'b1);

  // ---- stage p2: accumulate and burst control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      in_cnt_q  <= '0;
      acc_cnt_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      vld_p1_q  <= 1'b0;
    end else begin
      // in_ready is low outside RUN, so the valid bit only sets while running.
      vld_p1_q <= accept;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q     <= len;
            in_cnt_q  <= '0;
            acc_cnt_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            state_q   <= (len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (accept) in_cnt_q <= in_cnt_q + 1'b1;
          if (vld_p1_q) begin
            acc_q     <= acc_sum_d[ACC_W-1:0];
            ovf_q     <= ovf_q | acc_sum_d[ACC_W];
            acc_cnt_q <= acc_cnt_q + 1'b1;
            if (last_acc) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot4_seq.sv
// Bench for mac_dot4_seq: two instances (default 12-bit and 8-bit
// accumulator) share one stimulus stream. Burst sums are computed by plain
// arithmetic at start time and queued; a monitor pops and compares whenever
// the result is presented.
module tb_mac_dot4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [3:0] x, y;
  logic       out_ready;

  logic        in_ready_a, busy_a, out_valid_a, ovf_a;
  logic [11:0] result_a;
  logic        in_ready_b, busy_b, out_valid_b, ovf_b;
  logic [7:0]  result_b;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int px[16];
  int py[16];

  always #5 clk = ~clk;

  mac_dot4_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_a), .x(x), .y(y),
    .busy(busy_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .result(result_a), .ovf(ovf_a)
  );

  mac_dot4_seq #(.ACC_W(8), .LEN_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_b), .x(x), .y(y),
    .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .result(result_b), .ovf(ovf_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready_a,  0);
    chk({tag, "_out_valid"}, out_valid_a, 0);
    chk({tag, "_busy"},      busy_a,      0);
    chk({tag, "_result"},    result_a,    0);
    chk({tag, "_ovf"},       ovf_a,       0);
    chk({tag, "_out_valid8"}, out_valid_b, 0);
    chk({tag, "_result8"},   result_b,    0);
    chk({tag, "_ovf8"},      ovf_b,       0);
  endtask

  // Scoreboard monitor: compare whenever a result is presented, pop on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid_a) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d, expected no output (t=%0t)", result_a, $time);
      end else begin
        int s;
        s = exp_q[0];
        chk("result12", result_a, s % 4096);
        chk("ovf12",    ovf_a,    (s >= 4096) ? 1 : 0);
        chk("valid8",   out_valid_b, 1);
        chk("result8",  result_b, s % 256);
        chk("ovf8",     ovf_b,    (s >= 256) ? 1 : 0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Runs one burst from IDLE; caller is at posedge+1. gap_mode: 0 continuous,
  // 1 random in_valid gaps, 2 one idle cycle after the first pair.
  task automatic do_burst(input int n, input int gap_mode, input int hold, input bit poke_start);
    int s, idx, cyc, rdy;
    bit v, accepted, gap_done;
    s = 0;
    for (int i = 0; i < n; i++) s += px[i] * py[i];
    start = 1'b1;
    len   = 4'(n);
    exp_q.push_back(s);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy_a, 1);
    chk("acc_clear_on_start", result_a, 0);
    chk("ovf8_clear_on_start", ovf_b, 0);
    idx = 0; cyc = 0; rdy = 0; gap_done = 0;
    while (!out_valid_a && cyc < 300) begin
      if (in_ready_a) rdy++;
      v = (idx < n);
      if (gap_mode == 1 && $urandom_range(0, 2) == 0) v = 1'b0;
      if (gap_mode == 2 && idx == 1 && !gap_done) begin
        v = 1'b0;
        gap_done = 1'b1;
      end
      in_valid = v;
      x = v ? 4'(px[idx]) : 4'($urandom_range(0, 15));
      y = v ? 4'(py[idx]) : 4'($urandom_range(0, 15));
      accepted = v && in_ready_a;
      @(posedge clk); #1;
      if (accepted) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    if (!out_valid_a) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: got no out_valid, expected within %0d cycles", 300);
      exp_q.delete();
      return;
    end
    chk("pairs_taken", idx, n);
    chk("in_ready_low_in_done", in_ready_a, 0);
    if (gap_mode == 0) begin
      chk("latency", cyc, (n == 0) ? 0 : n + 1);
      chk("in_ready_edges", rdy, n);
    end
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = poke_start && (h == 0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("hold_out_valid", out_valid_a, 1);
    end
    out_ready = 1'b1;
    start = poke_start;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    chk("idle_after_handshake", busy_a, 0);
    chk("valid_drop", out_valid_a, 0);
    chk("result_kept", result_a, s % 4096);
    chk("ovf8_kept", ovf_b, (s >= 256) ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n;
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    x = '0; y = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous burst: 225 + 15 + 0 = 240
    px[0] = 15; py[0] = 15; px[1] = 3; py[1] = 5; px[2] = 0; py[2] = 9;
    do_burst(3, 0, 0, 0);

    // Input gap, backpressure, start poked during DONE: 63 + 4 = 67
    px[0] = 7; py[0] = 9; px[1] = 2; py[1] = 2;
    do_burst(2, 2, 3, 1);
    chk("start_in_done_ignored", busy_a, 0);

    // Zero length
    do_burst(0, 0, 1, 0);

    // Overflow on the 8-bit instance: 450 -> 194 with carry
    px[0] = 15; py[0] = 15; px[1] = 15; py[1] = 15;
    do_burst(2, 0, 1, 0);

    // Random bursts
    for (int b = 0; b < 25; b++) begin
      int n;
      n = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
        px[i] = $urandom_range(0, 15);
        py[i] = $urandom_range(0, 15);
      end
      do_burst(n, $urandom_range(0, 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Overflowing burst, then reset in the middle of the following burst
    for (int i = 0; i < 16; i++) begin px[i] = 15; py[i] = 15; end
    do_burst(4, 0, 0, 0);
    start = 1'b1; len = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ovf8_clear_on_start_midrun", ovf_b, 0);
    acc_n = 0;
    for (int c = 0; c < 20 && acc_n < 2; c++) begin
      bit a;
      in_valid = 1'b1; x = 4'd13; y = 4'd11;
      a = in_ready_a;
      @(posedge clk); #1;
      if (a) acc_n++;
    end
    in_valid = 1'b0;
    chk("midrun_pairs_before_reset", acc_n, 2);
    chk("midrun_partial_sum", result_a, 143);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("midrun_rst");
    @(posedge clk); #2;
    chk_reset_outputs("midrun_rst_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", busy_a, 0);
    px[0] = 4; py[0] = 4;
    do_burst(1, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
